// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared state and client encodings for the QSPI flash arbiter
package qspi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_STOP   = 2'd2
    } state_e;

    localparam logic CLI_DISPLAY = 1'b0;
    localparam logic CLI_HEADER  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, favouring the client not granted last
module rr_arbiter2
    import qspi_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt_idx = ~last_grant_q;
        end else begin
            gnt_idx = req[CLI_HEADER];
        end
        last_grant_d = advance ? gnt_idx : last_grant_q;
    end

    // Resetting to the header client hands the first tie to the display client.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_grant_q <= CLI_HEADER;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/qspi_flash_arbiter.sv
// rtl/qspi_flash_arbiter.sv - shares one QSPI DTR read engine between display and header clients
module qspi_flash_arbiter
    import qspi_pkg::*;
#(
    parameter int ADDR_BITS       = 24,
    parameter int LEN_BITS        = 12,
    parameter int DESELECT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [1:0]             req_valid,
    input  logic [2*ADDR_BITS-1:0] req_addr,
    input  logic [2*LEN_BITS-1:0]  req_len,
    output logic [1:0]             req_ready,
    output logic [7:0]             rd_data,
    output logic [1:0]             rd_valid,
    output logic                   rd_last,
    output logic [ADDR_BITS-1:0]   flash_addr,
    output logic                   flash_start,
    output logic                   flash_stop,
    input  logic [7:0]             flash_data,
    input  logic                   flash_valid
);

    localparam logic [3:0] DESEL_INIT = 4'(DESELECT_CYCLES);

    state_e               state_q, state_d;
    logic                 gnt_q, gnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] flash_addr_q, flash_addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [LEN_BITS-1:0]  cnt_q, cnt_d;
    logic [3:0]           desel_q, desel_d;
    logic [1:0]           req_ready_q, req_ready_d;
    logic [1:0]           rd_valid_q, rd_valid_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_last_q, rd_last_d;
    logic                 flash_start_q, flash_start_d;
    logic                 flash_stop_q, flash_stop_d;

    logic                 arb_valid, arb_idx, arb_advance;
    logic [ADDR_BITS-1:0] arb_addr, cur_addr, next_addr;
    logic [LEN_BITS-1:0]  arb_len, cur_len;
    logic                 cont_ok;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req_valid),
        .advance   (arb_advance),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    assign arb_addr  = (arb_idx == CLI_DISPLAY) ? req_addr[ADDR_BITS-1:0] : req_addr[2*ADDR_BITS-1:ADDR_BITS];
    assign arb_len   = (arb_idx == CLI_DISPLAY) ? req_len[LEN_BITS-1:0]   : req_len[2*LEN_BITS-1:LEN_BITS];
    assign cur_addr  = (gnt_q == CLI_DISPLAY)   ? req_addr[ADDR_BITS-1:0] : req_addr[2*ADDR_BITS-1:ADDR_BITS];
    assign cur_len   = (gnt_q == CLI_DISPLAY)   ? req_len[LEN_BITS-1:0]   : req_len[2*LEN_BITS-1:LEN_BITS];
    assign next_addr = addr_q + {{(ADDR_BITS-LEN_BITS){1'b0}}, len_q} + ADDR_BITS'(1);

    // Only extend the open stream when the other client is not waiting, so it cannot starve.
    assign cont_ok = req_valid[gnt_q] && (cur_addr == next_addr) && !req_valid[!gnt_q];

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        flash_addr_d  = flash_addr_q;
        rd_data_d     = rd_data_q;
        desel_d       = (desel_q != 4'd0) ? desel_q - 4'd1 : desel_q;
        req_ready_d   = 2'b00;
        rd_valid_d    = 2'b00;
        rd_last_d     = 1'b0;
        flash_start_d = 1'b0;
        flash_stop_d  = 1'b0;
        arb_advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (desel_q == 4'd0 && arb_valid) begin
                    arb_advance          = 1'b1;
                    gnt_d                = arb_idx;
                    addr_d               = arb_addr;
                    len_d                = arb_len;
                    cnt_d                = arb_len;
                    req_ready_d[arb_idx] = 1'b1;
                    flash_addr_d         = arb_addr;
                    flash_start_d        = 1'b1;
                    state_d              = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (flash_valid) begin
                    rd_data_d         = flash_data;
                    rd_valid_d[gnt_q] = 1'b1;
                    cnt_d             = cnt_q - LEN_BITS'(1);
                    if (cnt_q == '0) begin
                        rd_last_d = 1'b1;
                        if (cont_ok) begin
                            req_ready_d[gnt_q] = 1'b1;
                            addr_d             = next_addr;
                            len_d              = cur_len;
                            cnt_d              = cur_len;
                        end else begin
                            flash_stop_d = 1'b1;
                            state_d      = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                desel_d = DESEL_INIT;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // flash_stop resets high and the deselect counter resets loaded, so the engine starts idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            flash_addr_q  <= '0;
            rd_data_q     <= 8'd0;
            desel_q       <= DESEL_INIT;
            req_ready_q   <= 2'b00;
            rd_valid_q    <= 2'b00;
            rd_last_q     <= 1'b0;
            flash_start_q <= 1'b0;
            flash_stop_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            flash_addr_q  <= flash_addr_d;
            rd_data_q     <= rd_data_d;
            desel_q       <= desel_d;
            req_ready_q   <= req_ready_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
            flash_start_q <= flash_start_d;
            flash_stop_q  <= flash_stop_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign flash_addr  = flash_addr_q;
    assign flash_start = flash_start_q;
    assign flash_stop  = flash_stop_q;

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// tb/tb_qspi_flash_arbiter.sv - directed and randomized bursts checked against a burst-level model
module tb_qspi_flash_arbiter;

    localparam int AB    = 24;
    localparam int LB    = 12;
    localparam int DESEL = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [2*AB-1:0] req_addr = '0;
    logic [2*LB-1:0] req_len = '0;
    logic [1:0]      req_ready;
    logic [7:0]      rd_data;
    logic [1:0]      rd_valid;
    logic            rd_last;
    logic [AB-1:0]   flash_addr;
    logic            flash_start;
    logic            flash_stop;
    logic [7:0]      flash_data = 8'd0;
    logic            flash_valid = 1'b0;

    int total = 0, bad = 0, cyc = 0;
    int n_start = 0, n_stop = 0, n_rd = 0, n_both = 0, exp_rd = 0;
    int last_stop_cyc = -100, min_gap = 1000, fv_cyc = 0;
    int s0;

    qspi_flash_arbiter #(.ADDR_BITS(AB), .LEN_BITS(LB), .DESELECT_CYCLES(DESEL)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_last     (rd_last),
        .flash_addr  (flash_addr),
        .flash_start (flash_start),
        .flash_stop  (flash_stop),
        .flash_data  (flash_data),
        .flash_valid (flash_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge; expectations are checked in the main sequence.
    always @(negedge clk) begin
        if (rstn) begin
            if (flash_stop) begin
                n_stop++;
                last_stop_cyc = cyc;
            end
            if (flash_start) begin
                n_start++;
                if (cyc - last_stop_cyc < min_gap) min_gap = cyc - last_stop_cyc;
            end
            if (|rd_valid) n_rd++;
            if (&rd_valid) n_both++;
        end
    end

    function automatic logic [1:0] oh(input logic c);
        return c ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clients hold a request until they see its accept pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~req_ready;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic request(input logic c, input logic [AB-1:0] a, input int ln);
        if (c) begin
            req_addr[2*AB-1:AB] = a;
            req_len[2*LB-1:LB]  = LB'(ln);
        end else begin
            req_addr[AB-1:0] = a;
            req_len[LB-1:0]  = LB'(ln);
        end
        req_valid[c] = 1'b1;
    endtask

    task automatic wait_grant(input logic c, input logic [AB-1:0] a);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = flash_start;
        end
        chk("start_seen", 32'(seen), 32'd1);
        chk("start_addr", 32'(flash_addr), 32'(a));
        chk("grant_client", 32'(req_ready), 32'(oh(c)));
        settle($urandom_range(1, 3));
    endtask

    task automatic feed_byte(input logic c, input bit last, input bit cont);
        logic [7:0] d;
        d           = 8'($urandom);
        flash_data  = d;
        flash_valid = 1'b1;
        fv_cyc      = cyc;
        tick();
        flash_valid = 1'b0;
        exp_rd++;
        chk("rd_valid", 32'(rd_valid), 32'(oh(c)));
        chk("rd_data", 32'(rd_data), 32'(d));
        chk("rd_last", 32'(rd_last), 32'(last));
        chk("cont_ready", 32'(req_ready), cont ? 32'(oh(c)) : 32'd0);
        chk("stop_pulse", 32'(flash_stop), 32'(last && !cont));
        settle($urandom_range(1, 2));
    endtask

    // k sequential bursts from one client must ride a single flash start/stop pair.
    task automatic run_chain(input logic c, input logic [AB-1:0] a0, input int k, input int len0, input bit rnd);
        logic [AB-1:0] a;
        int p0, b0, ln, nln;
        b0  = n_start;
        p0  = n_stop;
        a   = a0;
        nln = 0;
        ln  = rnd ? int'($urandom_range(0, 3)) : len0;
        request(c, a, ln);
        wait_grant(c, a);
        for (int b = 0; b < k; b++) begin
            for (int i = 0; i <= ln; i++) begin
                if (i == ln && b < k - 1) begin
                    nln = rnd ? int'($urandom_range(0, 3)) : len0;
                    request(c, a + AB'(ln + 1), nln);
                end
                feed_byte(c, i == ln, i == ln && b < k - 1);
            end
            a  = a + AB'(ln + 1);
            ln = nln;
        end
        settle(DESEL + 6);
        chk("chain_starts", 32'(n_start - b0), 32'd1);
        chk("chain_stops", 32'(n_stop - p0), 32'd1);
        chk("stop_cycle", 32'(last_stop_cyc), 32'(fv_cyc + 1));
    endtask

    initial begin
        settle(3);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_flash_start", 32'(flash_start), 32'd0);
        chk("rst_flash_addr", 32'(flash_addr), 32'd0);
        chk("rst_flash_stop", 32'(flash_stop), 32'd1);
        rstn = 1'b1;
        chk("stop_first_cycle", 32'(flash_stop), 32'd1);
        tick();
        chk("stop_released", 32'(flash_stop), 32'd0);

        // Simultaneous requests alternate, display first.
        s0 = n_start;
        request(1'b0, 24'h000100, 0);
        request(1'b1, 24'h000200, 0);
        wait_grant(1'b0, 24'h000100);
        feed_byte(1'b0, 1'b1, 1'b0);
        wait_grant(1'b1, 24'h000200);
        feed_byte(1'b1, 1'b1, 1'b0);
        request(1'b0, 24'h000100, 0);
        request(1'b1, 24'h000200, 0);
        wait_grant(1'b0, 24'h000100);
        feed_byte(1'b0, 1'b1, 1'b0);
        wait_grant(1'b1, 24'h000200);
        feed_byte(1'b1, 1'b1, 1'b0);
        settle(DESEL + 6);
        chk("pair_starts", 32'(n_start - s0), 32'd4);

        // Single burst, then a stray engine byte while idle.
        run_chain(1'b0, 24'h001000, 1, 3, 1'b0);
        flash_valid = 1'b1;
        tick();
        flash_valid = 1'b0;
        chk("idle_drop", 32'(rd_valid), 32'd0);

        run_chain(1'b0, 24'h000400, 2, 7, 1'b0);
        run_chain(1'b1, 24'hFFFFFE, 2, 1, 1'b0);

        // Continuation refused because the other client is waiting.
        s0 = n_start;
        request(1'b0, 24'h000400, 7);
        wait_grant(1'b0, 24'h000400);
        for (int i = 0; i < 7; i++) feed_byte(1'b0, 1'b0, 1'b0);
        request(1'b0, 24'h000408, 7);
        request(1'b1, 24'h005000, 0);
        feed_byte(1'b0, 1'b1, 1'b0);
        wait_grant(1'b1, 24'h005000);
        feed_byte(1'b1, 1'b1, 1'b0);
        wait_grant(1'b0, 24'h000408);
        for (int i = 0; i < 8; i++) feed_byte(1'b0, i == 7, 1'b0);
        settle(DESEL + 6);
        chk("blocked_starts", 32'(n_start - s0), 32'd3);

        for (int t = 0; t < 4; t++) begin
            logic [AB-1:0] ra;
            ra = AB'($urandom);
            run_chain(1'(($urandom_range(0, 1))), ra, int'($urandom_range(1, 3)), 0, 1'b1);
        end

        // Reset while the second of six bytes arrives.
        request(1'b1, 24'h003000, 5);
        wait_grant(1'b1, 24'h003000);
        feed_byte(1'b1, 1'b0, 1'b0);
        flash_data  = 8'h5A;
        flash_valid = 1'b1;
        rstn        = 1'b0;
        tick();
        flash_valid = 1'b0;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_rd_last", 32'(rd_last), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_flash_start", 32'(flash_start), 32'd0);
        chk("mid_rst_flash_addr", 32'(flash_addr), 32'd0);
        chk("mid_rst_flash_stop", 32'(flash_stop), 32'd1);
        tick();
        rstn = 1'b1;
        s0 = n_start;
        request(1'b0, 24'h002000, 1);
        wait_grant(1'b0, 24'h002000);
        feed_byte(1'b0, 1'b0, 1'b0);
        feed_byte(1'b0, 1'b1, 1'b0);
        settle(DESEL + 6);
        chk("post_rst_starts", 32'(n_start - s0), 32'd1);

        chk("rd_strobe_count", 32'(n_rd), 32'(exp_rd));
        chk("rd_valid_onehot", 32'(n_both), 32'd0);
        chk("deselect_gap_ok", 32'(min_gap > DESEL), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
